// File: rtl/n0_unit_acc.sv
// Broadcast-neuron multiply-accumulate over TN lanes.
// Fixed-point product pipeline followed by a saturating accumulator.
module n0_unit_acc #(
    parameter int N           = 16,
    parameter int TN          = 16,
    parameter int MULT_STAGES = 2,
    parameter int FRAC        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_first,
    input  logic            i_last,
    input  logic [N-1:0]    i_nbin,
    input  logic [TN*N-1:0] i_sb,
    input  logic [TN*N-1:0] i_part_sum,
    output logic            o_valid,
    input  logic            i_out_ready,
    output logic [TN*N-1:0] o_res
);

    localparam int W = TN * N;
    localparam int L = MULT_STAGES - 1;

    localparam logic signed [2*N-1:0] PMAX =
        {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] PMIN =
        {{(N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [N-1:0] DMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] DMIN = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] mul_sat(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
        logic signed [2*N-1:0] ax;
        logic signed [2*N-1:0] bx;
        logic signed [2*N-1:0] p;
        logic signed [2*N-1:0] s;
        ax = $signed({{N{a[N-1]}}, a});
        bx = $signed({{N{b[N-1]}}, b});
        p  = ax * bx;
        s  = p >>> FRAC;
        if (s > PMAX) return DMAX;
        if (s < PMIN) return DMIN;
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] add_sat(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
        logic [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1]) return s[N] ? DMIN : DMAX;
        return s[N-1:0];
    endfunction

    logic                   stall;
    logic [W-1:0]           prod_in;
    logic [MULT_STAGES-1:0] sv;
    logic [MULT_STAGES-1:0] sf;
    logic [MULT_STAGES-1:0] sl;
    logic [W-1:0]           sp [MULT_STAGES];
    logic [W-1:0]           ss [MULT_STAGES];
    logic [W-1:0]           acc;
    logic [W-1:0]           acc_nx;

    // A held result blocks everything upstream, including acceptance.
    assign stall   = o_valid & ~i_out_ready;
    assign o_ready = ~stall;

    always_comb begin
        prod_in = '0;
        for (int l = 0; l < TN; l++) begin
            prod_in[l*N +: N] = mul_sat(i_nbin, i_sb[l*N +: N]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            sf <= '0;
            sl <= '0;
            for (int k = 0; k < MULT_STAGES; k++) begin
                sp[k] <= '0;
                ss[k] <= '0;
            end
        end else if (!stall) begin
            sv[0] <= i_valid;
            sf[0] <= i_first;
            sl[0] <= i_last;
            sp[0] <= prod_in;
            ss[0] <= i_part_sum;
            for (int k = 1; k < MULT_STAGES; k++) begin
                sv[k] <= sv[k-1];
                sf[k] <= sf[k-1];
                sl[k] <= sl[k-1];
                sp[k] <= sp[k-1];
                ss[k] <= ss[k-1];
            end
        end
    end

    always_comb begin
        acc_nx = '0;
        for (int l = 0; l < TN; l++) begin
            acc_nx[l*N +: N] = add_sat(
                sp[L][l*N +: N],
                sf[L] ? ss[L][l*N +: N] : acc[l*N +: N]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            o_valid <= 1'b0;
            o_res   <= '0;
        end else if (!stall) begin
            if (sv[L]) acc <= acc_nx;
            if (sv[L] && sl[L]) o_res <= acc_nx;
            o_valid <= sv[L] & sl[L];
        end
    end

endmodule

// File: tb/tb_n0_unit_acc.sv
// Directed bench for n0_unit_acc with a result scoreboard.
module tb_n0_unit_acc;

    localparam int N    = 16;
    localparam int TN   = 16;
    localparam int MS   = 2;
    localparam int FRAC = 8;
    localparam int W    = N * TN;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_first = 1'b0;
    logic         i_last = 1'b0;
    logic [N-1:0] i_nbin = '0;
    logic [W-1:0] i_sb = '0;
    logic [W-1:0] i_part_sum = '0;
    logic         i_out_ready = 1'b1;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_res;

    int checks = 0;
    int fails = 0;
    int delivered = 0;
    int pushed = 0;
    int d0;
    logic [W-1:0] sbq[$];
    logic [W-1:0] last_res = '0;
    int macc[TN];

    n0_unit_acc #(
        .N(N), .TN(TN), .MULT_STAGES(MS), .FRAC(FRAC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_first(i_first),
        .i_last(i_last),
        .i_nbin(i_nbin),
        .i_sb(i_sb),
        .i_part_sum(i_part_sum),
        .o_valid(o_valid),
        .i_out_ready(i_out_ready),
        .o_res(o_res)
    );

    always #5 clk = ~clk;

    function automatic int satn(longint v);
        longint lim;
        lim = longint'(1) <<< (N - 1);
        if (v > lim - 1) return int'(lim - 1);
        if (v < -lim) return int'(-lim);
        return int'(v);
    endfunction

    function automatic int mulq(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        p = p >>> FRAC;
        return satn(p);
    endfunction

    function automatic int lane(logic [W-1:0] v, int i);
        logic [N-1:0] t;
        t = v[i*N +: N];
        return int'($signed(t));
    endfunction

    function automatic logic [W-1:0] mk(int base, int step);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < TN; i++) begin
            v = base + step * i;
            r[i*N +: N] = v[N-1:0];
        end
        return r;
    endfunction

    task automatic chk_v(string tag, logic [W-1:0] obs,
                         logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_valid === 1'b1 &&
            i_out_ready === 1'b1) begin
            delivered++;
            last_res = o_res;
            chk_b("result_expected", sbq.size() != 0, 1'b1);
            if (sbq.size() != 0) chk_v("result", o_res, sbq.pop_front());
        end
    end

    task automatic send(int nb, logic [W-1:0] sb,
                        logic [W-1:0] ps, bit f, bit l);
        int n;
        int na;
        int t;
        bit ok;
        logic [W-1:0] e;
        logic [N-1:0] nbv;
        n = 0;
        ok = 1'b0;
        nbv = nb[N-1:0];
        i_valid = 1'b1;
        i_nbin = nbv;
        i_sb = sb;
        i_part_sum = ps;
        i_first = f;
        i_last = l;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            n++;
        end
        chk_b("accept", ok, 1'b1);
        if (ok) begin
            na = int'($signed(nbv));
            e = '0;
            for (int i = 0; i < TN; i++) begin
                t = satn(longint'(mulq(na, lane(sb, i))) +
                         longint'(f ? lane(ps, i) : macc[i]));
                macc[i] = t;
                e[i*N +: N] = t[N-1:0];
            end
            if (l) begin
                sbq.push_back(e);
                pushed++;
            end
        end
        #1;
    endtask

    // Garbage first/last while idle must have no effect.
    task automatic idle();
        i_valid = 1'b0;
        i_first = 1'b1;
        i_last = 1'b1;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk_i("drain", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TN; i++) macc[i] = 0;
        rst_n = 1'b0;
        #12;
        chk_b("rst_valid", o_valid, 1'b0);
        chk_v("rst_res", o_res, '0);
        chk_b("rst_ready", o_ready, 1'b1);
        #1 rst_n = 1'b1;
        chk_b("ready_after_rst", o_ready, 1'b1);
        tick(1);

        send(256, mk(768, 0), mk(9, 0), 1'b0, 1'b1);
        idle();
        wait_drain();
        chk_v("no_first_acc", last_res, mk(768, 0));

        send(256, mk(512, -37), mk(100, 3), 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk_b("lat_c1", o_valid, 1'b0);
        @(negedge clk);
        chk_b("lat_c2", o_valid, 1'b0);
        @(negedge clk);
        chk_b("lat_c3", o_valid, 1'b1);
        chk_i("single_lane0", lane(o_res, 0), 612);
        wait_drain();

        d0 = delivered;
        send(256, mk(256, 0), mk(0, 0), 1'b1, 1'b0);
        send(256, mk(256, 0), mk(0, 0), 1'b0, 1'b0);
        send(256, mk(256, 0), mk(0, 0), 1'b0, 1'b0);
        send(256, mk(256, 0), mk(0, 0), 1'b0, 1'b1);
        idle();
        wait_drain();
        chk_i("acc_count", delivered - d0, 1);
        chk_v("acc_1024", last_res, mk(1024, 0));

        send(32767, mk(32767, 0), mk(0, 0), 1'b1, 1'b1);
        idle();
        wait_drain();
        chk_v("sat_pos", last_res, mk(32767, 0));
        send(-32768, mk(32767, 0), mk(0, 0), 1'b1, 1'b1);
        idle();
        wait_drain();
        chk_v("sat_neg", last_res, mk(-32768, 0));
        send(-256, mk(256, 0), mk(0, 0), 1'b1, 1'b1);
        idle();
        wait_drain();
        chk_v("signed_mul", last_res, mk(-256, 0));

        i_out_ready = 1'b0;
        send(256, mk(300, 0), mk(1, 0), 1'b1, 1'b1);
        send(256, mk(-50, 0), mk(2, 0), 1'b1, 1'b1);
        idle();
        tick(4);
        @(negedge clk);
        chk_b("bp_valid", o_valid, 1'b1);
        chk_b("bp_ready", o_ready, 1'b0);
        chk_v("bp_res", o_res, mk(301, 0));
        tick(3);
        @(negedge clk);
        chk_v("bp_hold", o_res, mk(301, 0));
        chk_b("bp_ready_hold", o_ready, 1'b0);
        @(posedge clk);
        #1;
        d0 = delivered;
        i_out_ready = 1'b1;
        send(256, mk(10, 0), mk(0, 0), 1'b1, 1'b1);
        idle();
        wait_drain();
        chk_i("bp_count", delivered - d0, 3);
        chk_v("bp_last", last_res, mk(10, 0));

        send(256, mk(256, 0), mk(0, 0), 1'b1, 1'b0);
        send(256, mk(256, 0), mk(0, 0), 1'b0, 1'b0);
        idle();
        tick(1);
        rst_n = 1'b0;
        #2;
        chk_b("mid_rst_valid", o_valid, 1'b0);
        chk_v("mid_rst_res", o_res, '0);
        chk_b("mid_rst_ready", o_ready, 1'b1);
        for (int i = 0; i < TN; i++) macc[i] = 0;
        #1 rst_n = 1'b1;
        tick(1);
        d0 = delivered;
        send(256, mk(512, 0), mk(7, 0), 1'b1, 1'b1);
        idle();
        wait_drain();
        chk_i("post_rst_count", delivered - d0, 1);
        chk_v("post_rst_res", last_res, mk(519, 0));

        chk_i("total", delivered, pushed);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
